// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Sequential 4x4 unsigned multiplier with a binary-to-BCD converter and
// three 7-segment lamp drivers.
//
// One operation runs through the states IDLE -> MULT (4 cycles) ->
// CONV (8 cycles) -> DONE (1 cycle) -> IDLE. Operands are captured on the
// accept edge, so later changes on a/b do not affect the operation.
//
// Handshake: start is a request that is sampled only while busy=0. The edge
// that sees start=1 with the FSM in IDLE accepts the request, and busy rises
// right after it. Requests that arrive while busy=1 are dropped, not queued.
// done is a one-cycle pulse. It marks the cycle in which product and the
// lamps first show the new result.
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset
//   start         in   1  operation request, sampled only in IDLE
//   a             in   4  multiplicand, unsigned
//   b             in   4  multiplier, unsigned
//   busy          out  1  high whenever the FSM is not in IDLE
//   done          out  1  one-cycle pulse while in DONE
//   product       out  8  last completed product, registered
//   ones_lamp     out  7  7-seg code of the ones digit (bit6=a .. bit0=g)
//   tens_lamp     out  7  7-seg code of the tens digit
//   hundreds_lamp out  7  7-seg code of the hundreds digit
//
// Configuration macro:
//   MULT_LZ_BLANK_EN  when defined, leading zeros are blanked. The hundreds
//                     lamp is dark when its digit is 0. The tens lamp is dark
//                     when both the hundreds and tens digits are 0. The ones
//                     lamp is always lit.
// -----------------------------------------------------------------------------
module mult_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [6:0] ones_lamp,
    output logic [6:0] tens_lamp,
    output logic [6:0] hundreds_lamp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  step_cnt;
    logic [7:0]  mcand;    // multiplicand, shifted left by one place per step
    logic [3:0]  mplier;   // multiplier, shifted right; bit 0 is the current bit
    logic [7:0]  acc;      // partial product
    // Double-dabble working register laid out as
    // {hundreds[19:16], tens[15:12], ones[11:8], binary[7:0]}.
    logic [19:0] dd;

    logic [7:0]  acc_next;
    logic [19:0] dd_next;

    // Segment pattern for one decimal digit, active-high, bit6=a .. bit0=g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // All three lamps packed as {hundreds, tens, ones}, blanking applied.
    function automatic logic [20:0] lamps_of(input logic [3:0] h,
                                             input logic [3:0] t,
                                             input logic [3:0] o);
        logic [6:0] hl;
        logic [6:0] tl;
        hl = seg7(h);
        tl = seg7(t);
`ifdef MULT_LZ_BLANK_EN
        if (h == 4'd0) begin
            hl = 7'b0000000;
            if (t == 4'd0) begin
                tl = 7'b0000000;
            end
        end
`endif
        return {hl, tl, seg7(o)};
    endfunction

    // One double-dabble step. Any BCD nibble >= 5 gets 3 added, then the
    // whole register shifts left by one bit.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : 8'd0);
        dd_next  = dd_step(dd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_cnt <= 3'd0;
            mcand    <= 8'd0;
            mplier   <= 4'd0;
            acc      <= 8'd0;
            dd       <= 20'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= 8'd0;
            {hundreds_lamp, tens_lamp, ones_lamp} <= lamps_of(4'd0, 4'd0, 4'd0);
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand    <= {4'd0, a};
                        mplier   <= b;
                        acc      <= 8'd0;
                        step_cnt <= 3'd0;
                        busy     <= 1'b1;
                        state    <= MULT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                MULT: begin
                    acc      <= acc_next;
                    mcand    <= {mcand[6:0], 1'b0};
                    mplier   <= {1'b0, mplier[3:1]};
                    step_cnt <= step_cnt + 3'd1;
                    if (step_cnt == 3'd3) begin
                        // The product is complete. Load it into the converter.
                        dd       <= {12'd0, acc_next};
                        step_cnt <= 3'd0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    dd       <= dd_next;
                    step_cnt <= step_cnt + 3'd1;
                    if (step_cnt == 3'd7) begin
                        // The eighth shift finishes the BCD digits. Publish
                        // the result on the same edge that enters DONE.
                        product <= acc;
                        {hundreds_lamp, tens_lamp, ones_lamp} <=
                            lamps_of(dd_next[19:16], dd_next[15:12], dd_next[11:8]);
                        done     <= 1'b1;
                        step_cnt <= 3'd0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
//
// Directed and random stimulus for mult_seq_ctrl. The reference result comes
// from plain integer arithmetic: product = a*b. The decimal digits come from
// division, and a digit-to-segment table turns them into lamp codes.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [6:0] ones_lamp;
    logic [6:0] tens_lamp;
    logic [6:0] hundreds_lamp;

    int n_checks = 0;
    int n_fails  = 0;
    int prev_p   = 0;

    mult_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .product       (product),
        .ones_lamp     (ones_lamp),
        .tens_lamp     (tens_lamp),
        .hundreds_lamp (hundreds_lamp)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        return tbl[d];
    endfunction

    // Returns {hundreds, tens, ones} lamp codes for a value 0..255.
    function automatic logic [20:0] ref_lamps(input int p);
        int h;
        int t;
        int o;
        logic [6:0] hl;
        logic [6:0] tl;
        h  = p / 100;
        t  = (p / 10) % 10;
        o  = p % 10;
        hl = ref_seg(h);
        tl = ref_seg(t);
`ifdef MULT_LZ_BLANK_EN
        if (h == 0) hl = 7'b0000000;
        if (h == 0 && t == 0) tl = 7'b0000000;
`endif
        return {hl, tl, ref_seg(o)};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag, input int p);
        logic [20:0] l;
        l = ref_lamps(p);
        check({tag, "_product"},  product,               p[7:0]);
        check({tag, "_hundreds"}, {1'b0, hundreds_lamp}, {1'b0, l[20:14]});
        check({tag, "_tens"},     {1'b0, tens_lamp},     {1'b0, l[13:7]});
        check({tag, "_ones"},     {1'b0, ones_lamp},     {1'b0, l[6:0]});
    endtask

    // ---------------- driver ----------------
    // Called at 1 time unit after a rising edge, with the DUT idle.
    // Drives a one-cycle start, scrambles the operands after acceptance, and
    // checks the timing of done/busy and the published result.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input string tag);
        int p;
        int early_done;
        p          = int'(av) * int'(bv);
        early_done = 0;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk); #1;              // edge 0: accept
        start = 1'b0;
        check({tag, "_busy_e0"}, {7'd0, busy}, 8'd1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k < 12) begin
                a = 4'($urandom);
                b = 4'($urandom);
                if (done) early_done++;
            end
            if (k == 11) begin
                check({tag, "_early_done"}, 8'(early_done), 8'd0);
                check({tag, "_hold_prev"}, product, prev_p[7:0]);
            end
        end
        check({tag, "_done_e12"}, {7'd0, done}, 8'd1);
        check({tag, "_busy_e12"}, {7'd0, busy}, 8'd1);
        check_result(tag, p);
        @(posedge clk); #1;              // edge 13
        check({tag, "_done_e13"}, {7'd0, done}, 8'd0);
        check({tag, "_busy_e13"}, {7'd0, busy}, 8'd0);
        prev_p = p;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ndone;
        int done_edges[$];
        logic [3:0] ra;
        logic [3:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;

        // Reset state
        #12;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check_result("rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_op(4'd15, 4'd15, "max");
        run_op(4'd0,  4'd7,  "zero");
        run_op(4'd3,  4'd3,  "nine");
        run_op(4'd10, 4'd10, "hundred");
        run_op(4'd1,  4'd1,  "one");

        // start pulse while busy is ignored
        a = 4'd2; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;              // edge 0
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin a = 4'd9; b = 4'd9; start = 1'b1; end
            if (k == 5) start = 1'b0;
            if (done) begin
                ndone++;
                check("busy_ign_done_edge", 8'(k), 8'd12);
            end
            if (k == 12) check_result("busy_ign", 10);
        end
        check("busy_ign_ndone", 8'(ndone), 8'd1);
        check("busy_ign_idle", {7'd0, busy}, 8'd0);
        prev_p = 10;

        // Reset during CONV aborts the operation
        a = 4'd12; b = 4'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        check_result("abort", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        prev_p = 0;
        run_op(4'd12, 4'd11, "after_abort");

        // Random operands
        for (int i = 0; i < 10; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op(ra, rb, "rand");
        end

        // start held high: one operation every 14 cycles
        a = 4'd7; b = 4'd13; start = 1'b1;
        @(posedge clk); #1;              // edge 0
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_edges.push_back(k);
                check_result("held", 91);
            end
        end
        start = 1'b0;
        check("held_count", 8'(done_edges.size()), 8'd3);
        if (done_edges.size() == 3) begin
            check("held_first", 8'(done_edges[0]), 8'd12);
            check("held_gap1", 8'(done_edges[1] - done_edges[0]), 8'd14);
            check("held_gap2", 8'(done_edges[2] - done_edges[1]), 8'd14);
        end
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
        end
        check("final_idle", {7'd0, busy}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
